// File: rtl/timer0_pkg.sv
// Shared definitions for the timer0 interrupt master: timer register map,
// bit positions, FSM states and the per-state Avalon-MM bus drive values.
package timer0_pkg;

  localparam logic [2:0] ADDR_STATUS  = 3'd0;
  localparam logic [2:0] ADDR_CONTROL = 3'd1;
  localparam logic [2:0] ADDR_PERIODL = 3'd2;
  localparam logic [2:0] ADDR_PERIODH = 3'd3;

  localparam int STATUS_TO   = 0;
  localparam int STATUS_RUN  = 1;
  localparam int CONTROL_ITO = 0;

  typedef enum logic [3:0] {
    IDLE,
    EN_WR,
    WAIT_IRQ,
    RD_A,
    RD_B,
    CLR_WR,
    ACK_WAIT,
    RLD_WR,
    DIS_WR
  } state_e;

  typedef struct packed {
    logic        cs;
    logic        write_n;
    logic [2:0]  addr;
    logic [15:0] wdata;
  } bus_t;

  localparam bus_t BUS_IDLE = '{cs: 1'b0, write_n: 1'b1, addr: 3'd0, wdata: 16'd0};

  function automatic bus_t writeOf(logic [2:0] addr, logic [15:0] data);
    return '{cs: 1'b1, write_n: 1'b0, addr: addr, wdata: data};
  endfunction

  function automatic bus_t readOf(logic [2:0] addr);
    return '{cs: 1'b1, write_n: 1'b1, addr: addr, wdata: 16'd0};
  endfunction

  // Bus values the master drives while sitting in a given state.
  function automatic bus_t busForState(state_e st);
    bus_t b;
    b = BUS_IDLE;
    case (st)
      EN_WR:      b = writeOf(ADDR_CONTROL, 16'(1 << CONTROL_ITO));
      RD_A, RD_B: b = readOf(ADDR_STATUS);
      CLR_WR:     b = writeOf(ADDR_STATUS, 16'd0);
      RLD_WR:     b = writeOf(ADDR_PERIODL, 16'd0);
      DIS_WR:     b = writeOf(ADDR_CONTROL, 16'd0);
      default:    b = BUS_IDLE;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/timer0_irq_master.sv
// Avalon-MM initiator that enables the interval timer's interrupt, services
// each timeout (read + clear status) and exports a tick pulse and tick count.
module timer0_irq_master
  import timer0_pkg::*;
#(
  parameter int TICK_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              restart,
  output logic [2:0]        tmr_address,
  output logic              tmr_chipselect,
  output logic              tmr_write_n,
  output logic [15:0]       tmr_writedata,
  input  logic [15:0]       tmr_readdata,
  input  logic              tmr_irq,
  output logic              tick,
  output logic [TICK_W-1:0] tick_count,
  output logic              running,
  output logic              busy,
  output logic              spurious
);

  state_e            state_q, state_d;
  bus_t              bus_q, bus_d;
  logic              tick_q;
  logic [TICK_W-1:0] tickCount_q;
  logic              running_q;
  logic              spurious_q;
  logic              restartPend_q;
  logic              statusTo;
  logic              unusedReaddata;

  assign statusTo       = tmr_readdata[STATUS_TO];
  assign unusedReaddata = ^tmr_readdata[15:2];

  // Service beats reload, which beats disable; ACK_WAIT never looks at irq.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (enable) state_d = EN_WR;
      EN_WR:    state_d = WAIT_IRQ;
      WAIT_IRQ: begin
        if (tmr_irq)            state_d = RD_A;
        else if (restartPend_q) state_d = RLD_WR;
        else if (!enable)       state_d = DIS_WR;
      end
      RD_A:     state_d = RD_B;
      RD_B:     state_d = statusTo ? CLR_WR : WAIT_IRQ;
      CLR_WR:   state_d = ACK_WAIT;
      ACK_WAIT: state_d = WAIT_IRQ;
      RLD_WR:   state_d = WAIT_IRQ;
      DIS_WR:   state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Bus and tick are registered from the next state so they line up with it.
  assign bus_d = busForState(state_d);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      bus_q         <= BUS_IDLE;
      tick_q        <= 1'b0;
      tickCount_q   <= '0;
      running_q     <= 1'b0;
      spurious_q    <= 1'b0;
      restartPend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bus_q   <= bus_d;
      tick_q  <= (state_d == CLR_WR);
      if (state_q == CLR_WR) tickCount_q <= tickCount_q + TICK_W'(1);
      if (state_q == RD_B) begin
        running_q <= tmr_readdata[STATUS_RUN];
        if (!statusTo) spurious_q <= 1'b1;
      end
      // A new pulse in the reload cycle itself wins and schedules another reload.
      if (restart)                 restartPend_q <= 1'b1;
      else if (state_q == RLD_WR)  restartPend_q <= 1'b0;
    end
  end

  assign tmr_chipselect = bus_q.cs;
  assign tmr_write_n    = bus_q.write_n;
  assign tmr_address    = bus_q.addr;
  assign tmr_writedata  = bus_q.wdata;
  assign tick           = tick_q;
  assign tick_count     = tickCount_q;
  assign running        = running_q;
  assign spurious       = spurious_q;
  assign busy           = !(state_q inside {IDLE, WAIT_IRQ});

endmodule

// File: doc/timer0_irq_master.md
# timer0_irq_master

Avalon-MM initiator that owns the interval-timer slave's `s1` port on behalf of logic that has no CPU path to it. It enables the timer interrupt, services each timeout by reading and clearing the status register, and exports a one-cycle `tick` pulse plus a running tick count. It also handles restart (counter reload) and disable requests. It sits between the timer slave and any fabric logic that needs a periodic time base.

## Interface
- `TICK_W`, default 32: width of `tick_count`.
- `clk  in  1`: single clock, shared with the timer slave.
- `reset  in  1`: synchronous, active-high.
- `enable  in  1`: level. High requests timer interrupts on; low requests off.
- `restart  in  1`: single-cycle pulse requesting a counter reload.
- `tmr_address  out  3`: register address, driven to the slave.
- `tmr_chipselect  out  1`: slave select.
- `tmr_write_n  out  1`: active-low write strobe.
- `tmr_writedata  out  16`: write data.
- `tmr_readdata  in  16`: slave read data. The slave registers it, giving one cycle of latency from address.
- `tmr_irq  in  1`: slave interrupt (timeout AND interrupt-enable).
- `tick  out  1`: one-cycle pulse per serviced timeout.
- `tick_count  out  TICK_W`: number of serviced timeouts. Wraps to 0 after its maximum value.
- `running  out  1`: RUN bit (status bit 1) captured at the last status read.
- `busy  out  1`: high in every state except IDLE and WAIT_IRQ.
- `spurious  out  1`: sticky flag. Set when a status read taken after `tmr_irq` shows TO=0. Cleared only by reset.

## Operation
- Register map used: 0 = STATUS (bit0 TO, bit1 RUN; any write clears TO), 1 = CONTROL (bit0 ITO), 2 = PERIODL (any write forces a reload).
- Idle bus values: `tmr_chipselect`=0, `tmr_write_n`=1, `tmr_address`=0, `tmr_writedata`=0.
- A write is exactly one cycle with `tmr_chipselect`=1, `tmr_write_n`=0, and address and data valid.
- A read holds `tmr_chipselect`=1, `tmr_write_n`=1 and the address for two cycles. `tmr_readdata` is sampled at the end of the second cycle.
- FSM states and transitions:
  - IDLE: if `enable`, go to EN_WR.
  - EN_WR: write CONTROL=1, then go to WAIT_IRQ.
  - WAIT_IRQ: on `tmr_irq`, go to RD_A. Otherwise, if `restart_pend`, go to RLD_WR. Otherwise, if !`enable`, go to DIS_WR. Otherwise stay.
  - RD_A, then RD_B: read STATUS. At the end of RD_B, capture `running`. If TO=1, go to CLR_WR. If TO=0, set `spurious` and go to WAIT_IRQ.
  - CLR_WR: write STATUS=0. Assert `tick`. Increment `tick_count` at the end of the cycle. Go to ACK_WAIT.
  - ACK_WAIT: one cycle to let `tmr_irq` fall, then go to WAIT_IRQ.
  - RLD_WR: write PERIODL=0, clear `restart_pend`, go to WAIT_IRQ.
  - DIS_WR: write CONTROL=0, then go to IDLE.
- `restart` in any state sets `restart_pend`. `restart_pend` is serviced only in WAIT_IRQ. Multiple pulses while it is pending collapse into one reload.
- Priority in WAIT_IRQ: irq service, then reload, then disable. Deasserting `enable` mid-service does not abort the service; disable follows on return to WAIT_IRQ.
- In IDLE, `restart` is still latched, and the reload is performed after the next enable.

## Timing
- Reset values: bus at idle values; `tick`=0, `tick_count`=0, `running`=0, `busy`=0, `spurious`=0, `restart_pend`=0, state IDLE.
- Reset asserted mid-transaction forces idle bus values on the next cycle. No partial write is repeated.
- irq latency: `tmr_irq` seen high in WAIT_IRQ at cycle 0, then RD_A in cycle 1, RD_B in cycle 2, CLR_WR with `tick` in cycle 3, ACK_WAIT in cycle 4, WAIT_IRQ in cycle 5. One service takes 5 cycles.
- `tmr_irq` is ignored in ACK_WAIT, so the stale level is not re-serviced.
- A timeout arriving while a service is in progress is seen at the next WAIT_IRQ only if the slave's TO bit was set after the CLR_WR write.
- `enable` rising in IDLE: the EN_WR write occurs in the next cycle.

## Structure
- Package `timer0_pkg`:
  - address constants ADDR_STATUS=0, ADDR_CONTROL=1, ADDR_PERIODL=2, ADDR_PERIODH=3;
  - bit indices STATUS_TO=0, STATUS_RUN=1, CONTROL_ITO=0;
  - the FSM state enum.
- Single flat module with no sub-modules. All outputs are registered except `busy`, which is decoded from the state.

## Test plan
- Use a behavioural slave model with registered readdata and a programmable timeout period.
- Reset, then `enable`=1 → one write CONTROL=0x0001 at address 1. `busy` is high for one cycle and the bus then returns to idle values.
- Slave raises irq with status 0x0003 → read of address 0 held for 2 cycles, then write address 0 with 0x0000. `tick` is high exactly one cycle, `tick_count` 0→1, `running`=1, and no second service occurs.
- irq forced high with status 0x0002 → `spurious`=1, no `tick`, `tick_count` unchanged.
- `restart` pulsed twice during a service → after ACK_WAIT, exactly one write to address 2 with 0x0000.
- `enable` dropped in RD_B → service completes with `tick`, then one write CONTROL=0x0000, then IDLE.
- `tick_count` preset near all-ones (TICK_W=4, 15 ticks) → the next tick wraps it to 0.
- Reset asserted during CLR_WR → the next cycle shows all reset values and idle bus values.
